cfg_memory_dbuf: RTL and testbench
==================================

Name: cfg_memory_dbuf

Overview:
- Double-buffered, parametrised configuration memory for the SNN weight/delay store.
- A narrow byte stream loads a shadow bank through a valid/ready handshake. Beats are packed into N-bit words, and the write pointer auto-increments.
- A commit copies the shadow bank atomically into the active bank.
- The active bank drives the flattened parallel output to the neuron array and a random-access read port. The network therefore never sees a partially loaded configuration.

Parameters:
- M, 320: number of words (depth).
- N, 8: word width in bits.
- IW, 8: input beat width in bits. N must be an integer multiple of IW. K = N/IW beats per word.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load_start  in  1  single-cycle pulse. Restarts loading at word 0.
- in_data  in  IW  stream beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- commit  in  1  single-cycle pulse. Copies the shadow bank to the active bank.
- rd_addr  in  $clog2(M)  read address into the active bank.
- rd_data  out  N  active[rd_addr], combinational.
- all_data_out  out  M*N  active[i] at bits [i*N +: N], combinational.
- load_done  out  1  level. The shadow bank holds a complete M-word load.
- commit_ack  out  1  one-cycle pulse after a successful commit.

Behaviour:
- Reset (async):
  - Both banks cleared to 0; state IDLE.
  - Word pointer and beat counter 0; assembly register 0.
  - in_ready=0, load_done=0, commit_ack=0.
  - rd_data and all_data_out therefore read 0.
- States:
  - IDLE: in_ready=0.
  - LOAD: in_ready=1.
  - FULL: in_ready=0, load_done=1.
- load_start, in any state: next state LOAD, pointer=0, beat=0, assembly register cleared, load_done=0. An in_valid beat in the same cycle is not accepted, because in_ready is computed from the current state and the load_start cycle discards any transfer.
- LOAD:
  - A transfer occurs when in_valid & in_ready & !load_start.
  - Beats are packed little-endian: beat j of a word goes to bits [j*IW +: IW].
  - On beat K-1, the full word (assembly bits plus current beat) is written to shadow[pointer]. Then pointer increments and beat returns to 0.
  - The write of word M-1 transitions to FULL on the next edge. in_ready drops in that same edge.
  - No beat is ever written past M-1 (no wrap).
  - A K=1 configuration writes one word per beat.
- commit:
  - Accepted only when state==FULL at the edge. All M shadow words are copied to active in one cycle; commit_ack=1 in the following cycle only.
  - State stays FULL, so repeated commits are allowed and idempotent.
  - A commit in IDLE or LOAD is ignored: no copy, no ack, active unchanged.
- commit and load_start in the same cycle while FULL: the commit executes (copy from the current shadow, ack issued) and the load restarts.
- Active-bank outputs change only on a commit edge or a reset. Shadow writes are never visible on rd_data or all_data_out.
- A reset asserted mid-load or mid-commit clears everything immediately. No partial commit is retained.
- rd_addr ≥ M returns 0.

Optional Feature:
- Macro: CFGMEM_SHADOW_READ_EN.
- When defined:
  - Adds input rd_shadow (1 bit).
  - When rd_shadow=1, rd_data returns shadow[rd_addr] instead of active[rd_addr]. This provides load readback and verification before commit.
  - all_data_out always reflects active.
- When undefined: no rd_shadow port; rd_data always reads active.

Test Plan (M=4, N=16, IW=8 unless stated):
- Reset, then load_start, then 8 beats 0x11,0x22,…,0x88 with in_valid held high:
  - in_ready=1 for 8 cycles, then 0; load_done=1.
  - all_data_out still 0.
  - After commit: all_data_out=0x8877_6655_4433_2211, commit_ack pulses once, rd_addr=2 gives 0x6655.
- Same load with in_valid toggled every other cycle: same final contents. No beat is dropped or duplicated.
- commit in LOAD after 3 beats: no ack, active unchanged. Finish the load, then commit: ack, and contents are correct.
- While FULL, load_start and commit in the same cycle:
  - Old shadow is committed, ack issued.
  - State LOAD, load_done=0, in_ready=1.
  - A beat offered in that cycle is not written.
- Reset asserted after 5 beats: in_ready=0, load_done=0, both banks 0 immediately. A subsequent in_valid in IDLE is not accepted.
- With CFGMEM_SHADOW_READ_EN: after a full load, before commit, rd_shadow=1 and rd_addr=1 give 0x4433, while rd_shadow=0 gives 0x0000.

Source files
------------

// File: rtl/cfg_memory_dbuf.sv
// Double-buffered configuration memory: a byte stream fills the shadow bank, and a commit copies
// it to the active bank that feeds the neuron array. Optional macro CFGMEM_SHADOW_READ_EN.
module cfg_memory_dbuf #(
  parameter int unsigned M  = 320,
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [IW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 commit,
`ifdef CFGMEM_SHADOW_READ_EN
  input  logic                 rd_shadow,
`endif
  input  logic [$clog2(M)-1:0] rd_addr,
  output logic [N-1:0]         rd_data,
  output logic [M*N-1:0]       all_data_out,
  output logic                 load_done,
  output logic                 commit_ack
);

  localparam int unsigned K  = N / IW;
  localparam int unsigned AW = $clog2(M);
  localparam int unsigned BW = (K > 1) ? $clog2(K) : 1;
  localparam logic [AW:0] MLim = (AW + 1)'(M);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StFull = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [N-1:0]  asm_q, asm_d;
  logic          ack_q, ack_d;
  logic [N-1:0]  shadow_q [M];
  logic [N-1:0]  shadow_d [M];
  logic [N-1:0]  active_q [M];
  logic [N-1:0]  active_d [M];

  logic          xfer, last_beat, commit_ok;
  logic [N-1:0]  word;

  assign in_ready   = (state_q == StLoad);
  assign load_done  = (state_q == StFull);
  assign commit_ack = ack_q;
  assign xfer       = in_valid & in_ready & ~load_start;
  assign last_beat  = (beat_q == BW'(K - 1));
  assign commit_ok  = commit & (state_q == StFull);

  // Assembly register with the current beat merged into its little-endian slot.
  always_comb begin
    word = asm_q;
    for (int unsigned j = 0; j < K; j++) begin
      if (beat_q == BW'(j)) word[j*IW +: IW] = in_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    shadow_d = shadow_q;
    if (load_start) begin
      state_d = StLoad;
      ptr_d   = '0;
      beat_d  = '0;
      asm_d   = '0;
    end else if (xfer) begin
      if (last_beat) begin
        shadow_d[ptr_q] = word;
        asm_d           = '0;
        beat_d          = '0;
        // Pointer never advances past the final word; the bank is then full.
        if (ptr_q == AW'(M - 1)) state_d = StFull;
        else                     ptr_d   = ptr_q + AW'(1);
      end else begin
        asm_d  = word;
        beat_d = beat_q + BW'(1);
      end
    end
  end

  // Commit samples the shadow before any same-cycle restart can touch it.
  always_comb begin
    active_d = active_q;
    if (commit_ok) active_d = shadow_q;
    ack_d = commit_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      beat_q   <= '0;
      asm_q    <= '0;
      ack_q    <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      asm_q    <= asm_d;
      ack_q    <= ack_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < MLim) begin
`ifdef CFGMEM_SHADOW_READ_EN
      if (rd_shadow) rd_data = shadow_q[rd_addr];
      else           rd_data = active_q[rd_addr];
`else
      rd_data = active_q[rd_addr];
`endif
    end
  end

  always_comb begin
    all_data_out = '0;
    for (int unsigned i = 0; i < M; i++) begin
      all_data_out[i*N +: N] = active_q[i];
    end
  end

endmodule

// File: tb/tb_cfg_memory_dbuf.sv
// Directed bench for cfg_memory_dbuf at M=4, N=16, IW=8: a vector table for the basic
// load/commit flow, then hand sequences for gapped input, early commit, restart and reset.
module tb_cfg_memory_dbuf;

  localparam int unsigned M  = 4;
  localparam int unsigned N  = 16;
  localparam int unsigned IW = 8;

  localparam logic [63:0] P1 = 64'h8877_6655_4433_2211;
  localparam logic [63:0] P2 = 64'h0807_0605_0403_0201;
  localparam logic [63:0] P3 = 64'hC8C7_C6C5_C4C3_C2C1;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          commit;
  logic [1:0]    rd_addr;
  logic [N-1:0]  rd_data;
  logic [M*N-1:0] all_data_out;
  logic          load_done;
  logic          commit_ack;
`ifdef CFGMEM_SHADOW_READ_EN
  logic          rd_shadow;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cfg_memory_dbuf #(.M(M), .N(N), .IW(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .commit       (commit),
`ifdef CFGMEM_SHADOW_READ_EN
    .rd_shadow    (rd_shadow),
`endif
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .all_data_out (all_data_out),
    .load_done    (load_done),
    .commit_ack   (commit_ack)
  );

  typedef struct {
    logic        ls;
    logic        vld;
    logic [7:0]  dat;
    logic        cmt;
    logic [1:0]  addr;
    logic        exp_rdy;
    logic        exp_done;
    logic        exp_ack;
    logic [15:0] exp_rd;
    logic [63:0] exp_all;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input vec_t v);
    chk({nm, ".in_ready"}, 64'(in_ready), 64'(v.exp_rdy));
    chk({nm, ".load_done"}, 64'(load_done), 64'(v.exp_done));
    chk({nm, ".commit_ack"}, 64'(commit_ack), 64'(v.exp_ack));
    chk({nm, ".rd_data"}, 64'(rd_data), 64'(v.exp_rd));
    chk({nm, ".all_data_out"}, all_data_out, v.exp_all);
  endtask

  // Drive one cycle's inputs, check outputs after settling, then advance one edge.
  task automatic apply_vec(input string nm, input vec_t v);
    load_start = v.ls;
    in_valid   = v.vld;
    in_data    = v.dat;
    commit     = v.cmt;
    rd_addr    = v.addr;
    #1;
    check_outs(nm, v);
    @(posedge clk);
    #1;
  endtask

  // Accepted beat during LOAD, active bank expected to hold act.
  task automatic beat(input string nm, input logic [7:0] d, input logic [63:0] act);
    apply_vec(nm, '{1'b0, 1'b1, d, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, act[15:0], act});
  endtask

  vec_t tbl [13];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{1'b0, 1'b1, 8'(i * 8'h11), 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0};
    end
    tbl[9]  = '{1'b0, 1'b1, 8'h99, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0, 64'h0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, 64'h0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 16'h6655, P1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 16'h8877, P1};

    reset      = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    commit     = 1'b0;
    rd_addr    = '0;
`ifdef CFGMEM_SHADOW_READ_EN
    rd_shadow  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", '{1'b0, 1'b0, 8'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0});
    reset = 1'b0;

    // Basic load then commit, with an ignored beat on the load_start cycle.
    for (int i = 0; i < 13; i++) begin
`ifdef CFGMEM_SHADOW_READ_EN
      if (i == 9) begin
        rd_addr   = 2'd1;
        rd_shadow = 1'b1;
        #1;
        chk("shadow_read", 64'(rd_data), 64'h4433);
        rd_shadow = 1'b0;
      end
`endif
      apply_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Gapped input: beats only on alternate cycles, junk data on idle cycles.
    apply_vec("gap.ls", '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h2211, P1});
    for (int j = 0; j < 8; j++) begin
      beat($sformatf("gap.b%0d", j), 8'(j + 1), P1);
      apply_vec($sformatf("gap.idle%0d", j),
                '{1'b0, 1'b0, 8'hEE, 1'b0, 2'd0, (j != 7), (j == 7), 1'b0, 16'h2211, P1});
    end
    apply_vec("gap.cmt", '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h2211, P1});
    apply_vec("gap.ack", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0201, P2});

    // Commit during LOAD is ignored; commit after the load completes takes effect.
    apply_vec("early.ls", '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0201, P2});
    for (int j = 1; j <= 3; j++) beat($sformatf("early.b%0d", j), 8'(j * 8'h11), P2);
    apply_vec("early.cmt", '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0201, P2});
    apply_vec("early.noack", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0201, P2});
    for (int j = 4; j <= 8; j++) beat($sformatf("early.b%0d", j), 8'(j * 8'h11), P2);
    apply_vec("early.cmt2", '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0201, P2});
    apply_vec("early.ack", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'h2211, P1});

    // Restart and commit together while FULL; the same-cycle beat must be dropped.
    apply_vec("both.ls", '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h2211, P1});
    for (int j = 1; j <= 8; j++) beat($sformatf("both.b%0d", j), 8'(j), P1);
    apply_vec("both.go", '{1'b1, 1'b1, 8'hFF, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h2211, P1});
    apply_vec("both.b1", '{1'b0, 1'b1, 8'hC1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'h0201, P2});
    for (int j = 2; j <= 8; j++) beat($sformatf("both.b%0d", j), 8'(8'hC0 + j), P2);
    apply_vec("both.cmt", '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0201, P2});
    apply_vec("both.ack", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 16'hC8C7, P3});

    // Asynchronous reset in the middle of a load.
    apply_vec("rst.ls", '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'hC2C1, P3});
    for (int j = 1; j <= 5; j++) beat($sformatf("rst.b%0d", j), 8'(j * 8'h11), P3);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'h0);
    chk("rst.load_done", 64'(load_done), 64'h0);
    chk("rst.all_data_out", all_data_out, 64'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk($sformatf("rst.rd%0d", a), 64'(rd_data), 64'h0);
    end
    reset = 1'b0;
    apply_vec("rst.idle0", '{1'b0, 1'b1, 8'h5A, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0});
    apply_vec("rst.idle1", '{1'b0, 1'b1, 8'hA5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0});
    apply_vec("rst.idle2", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
